// File: rtl/rat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rat_pkg
// Description : Shared types for the rational-op scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package rat_pkg;

    localparam int c_RAT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } rat_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } rat_state_e;

endpackage
`default_nettype wire

// File: rtl/rat_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : rat_sched_if
// Description : Request, shared-unit and response signals of the scheduler.
//               slave = scheduler view, master = clients/unit/consumer view.
// Revision    : 1.0  initial release
// ============================================================================
interface rat_sched_if
    import rat_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = c_RAT_WIDTH_DEF
);
    localparam int c_IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_l_num;
    logic [WIDTH*NREQ-1:0] req_l_den;
    logic [WIDTH*NREQ-1:0] req_r_num;
    logic [WIDTH*NREQ-1:0] req_r_den;

    logic                  u_start;
    logic [1:0]            u_op;
    logic [WIDTH-1:0]      u_l_num;
    logic [WIDTH-1:0]      u_l_den;
    logic [WIDTH-1:0]      u_r_num;
    logic [WIDTH-1:0]      u_r_den;
    logic [WIDTH-1:0]      u_s_num;
    logic [WIDTH-1:0]      u_s_den;
    logic                  u_rdy;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [c_IDW-1:0]      rsp_id;
    logic [WIDTH-1:0]      rsp_num;
    logic [WIDTH-1:0]      rsp_den;
    logic                  rsp_dz;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_op, req_l_num, req_l_den, req_r_num, req_r_den,
        output req_ready,
        output u_start, u_op, u_l_num, u_l_den, u_r_num, u_r_den,
        input  u_s_num, u_s_den, u_rdy,
        output rsp_valid, rsp_id, rsp_num, rsp_den, rsp_dz, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_l_num, req_l_den, req_r_num, req_r_den,
        input  req_ready,
        input  u_start, u_op, u_l_num, u_l_den, u_r_num, u_r_den,
        output u_s_num, u_s_den, u_rdy,
        input  rsp_valid, rsp_id, rsp_num, rsp_den, rsp_dz, rsp_err,
        output rsp_ready
    );

endinterface
`default_nettype wire

// File: rtl/rat_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rat_rr_arb
// Description : Combinational round-robin picker: first request at or after
//               i_ptr, wrapping, as a one-hot grant.
// Revision    : 1.0  initial release
// ============================================================================
module rat_rr_arb
    import rat_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  wire logic [NREQ-1:0]         i_req,
    input  wire logic [$clog2(NREQ)-1:0] i_ptr,
    output logic      [NREQ-1:0]         o_gnt
);
    localparam int c_PW  = $clog2(NREQ);
    localparam int c_PW1 = c_PW + 1;

    logic [c_PW:0] w_pos;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One spare bit so ptr+k can be folded back into 0..NREQ-1
            w_pos = {1'b0, i_ptr} + c_PW1'(k);
            if (w_pos >= c_PW1'(NREQ)) begin
                w_pos = w_pos - c_PW1'(NREQ);
            end
            if (!w_found && i_req[w_pos[c_PW-1:0]]) begin
                o_gnt[w_pos[c_PW-1:0]] = 1'b1;
                w_found                = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rat_sched.sv
`default_nettype none
// ============================================================================
// Module      : rat_sched
// Description : Round-robin scheduler sharing one multi-cycle rational unit
//               among NREQ requesters. Optional watchdog: RAT_SCHED_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module rat_sched
    import rat_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = c_RAT_WIDTH_DEF,
    parameter int TIMEOUT = 64
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rat_sched_if.slave bus
);
    localparam int c_IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("rat_sched: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    rat_state_e       r_state;
    rat_state_e       w_state_nxt;
    logic [c_IDW-1:0] r_ptr;
    logic [c_IDW-1:0] r_id;
    logic [c_IDW-1:0] w_gnt_id;
    logic [c_IDW-1:0] w_ptr_nxt;
    logic [NREQ-1:0]  w_gnt;
    logic [NREQ-1:0]  w_ready;
    logic             w_accept;
    logic             w_rdy_take;
    logic             w_tmo_hit;
    logic             w_rsp_err;

    rat_op_e          r_op;
    rat_op_e          w_sel_op;
    logic [WIDTH-1:0] r_l_num, r_l_den, r_r_num, r_r_den;
    logic [WIDTH-1:0] w_sel_l_num, w_sel_l_den, w_sel_r_num, w_sel_r_den;
    logic [WIDTH-1:0] r_rsp_num, r_rsp_den;
    logic             r_rsp_dz;

    rat_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    assign w_ready    = (r_state == ST_IDLE) ? w_gnt : '0;
    assign w_accept   = |(bus.req_valid & w_ready);
    assign w_rdy_take = (r_state == ST_WAIT) && bus.u_rdy;

    always_comb begin
        w_gnt_id    = '0;
        w_sel_op    = OP_ADD;
        w_sel_l_num = '0;
        w_sel_l_den = '0;
        w_sel_r_num = '0;
        w_sel_r_den = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_id    = c_IDW'(i);
                w_sel_op    = rat_op_e'(bus.req_op[2*i +: 2]);
                w_sel_l_num = bus.req_l_num[WIDTH*i +: WIDTH];
                w_sel_l_den = bus.req_l_den[WIDTH*i +: WIDTH];
                w_sel_r_num = bus.req_r_num[WIDTH*i +: WIDTH];
                w_sel_r_den = bus.req_r_den[WIDTH*i +: WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_id == c_IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.u_rdy || w_tmo_hit) w_state_nxt = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_op      <= OP_ADD;
            r_l_num   <= '0;
            r_l_den   <= '0;
            r_r_num   <= '0;
            r_r_den   <= '0;
            r_rsp_num <= '0;
            r_rsp_den <= '0;
            r_rsp_dz  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr   <= w_ptr_nxt;
                r_id    <= w_gnt_id;
                r_op    <= w_sel_op;
                r_l_num <= w_sel_l_num;
                r_l_den <= w_sel_l_den;
                r_r_num <= w_sel_r_num;
                r_r_den <= w_sel_r_den;
            end
            if (w_rdy_take) begin
                r_rsp_num <= bus.u_s_num;
                r_rsp_den <= bus.u_s_den;
                r_rsp_dz  <= (bus.u_s_den == '0);
            end else if (w_tmo_hit) begin
                r_rsp_num <= '0;
                r_rsp_den <= '0;
                r_rsp_dz  <= 1'b1;
            end
        end
    end

`ifdef RAT_SCHED_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic               r_rsp_err;

    // Fires on the TIMEOUT-th WAIT cycle that sees no u_rdy
    assign w_tmo_hit = (r_state == ST_WAIT) && !bus.u_rdy &&
                       (r_tmo_cnt == c_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_rdy_take) begin
                r_rsp_err <= 1'b0;
            end else if (w_tmo_hit) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign w_rsp_err = r_rsp_err;
`else
    assign w_tmo_hit = 1'b0;
    assign w_rsp_err = 1'b0;
`endif

    assign bus.req_ready = w_ready;
    assign bus.u_start   = (r_state == ST_ISSUE);
    assign bus.u_op      = r_op;
    assign bus.u_l_num   = r_l_num;
    assign bus.u_l_den   = r_l_den;
    assign bus.u_r_num   = r_r_num;
    assign bus.u_r_den   = r_r_den;
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_num   = r_rsp_num;
    assign bus.rsp_den   = r_rsp_den;
    assign bus.rsp_dz    = r_rsp_dz;
    assign bus.rsp_err   = w_rsp_err;

endmodule
`default_nettype wire

// File: doc/rat_sched.md
# rat_sched

Round-robin scheduler that shares one multi-cycle rational arithmetic unit (add/sub/mul/div on num/den pairs) among NREQ requesters. It accepts one operation at a time and latches the operands. It then sequences the unit through start/ready and returns the result, tagged with the requester id, over a valid/ready response channel. It sits between the rational-op clients and the single shared rational datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, numerator/denominator width
- TIMEOUT, 64, watchdog limit in cycles (used only with RAT_SCHED_TIMEOUT_EN)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester op request
- req_ready  out  NREQ  one-hot grant/accept
- req_op  in  2*NREQ  op per requester: 0 ADD, 1 SUB, 2 MUL, 3 DIV
- req_l_num, req_l_den, req_r_num, req_r_den  in  WIDTH*NREQ each  operands, requester i at slice i
- u_start  out  1  one-cycle start pulse to the unit
- u_op  out  2  latched op
- u_l_num, u_l_den, u_r_num, u_r_den  out  WIDTH each  latched operands
- u_s_num, u_s_den  in  WIDTH each  unit result
- u_rdy  in  1  unit result valid
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  $clog2(NREQ)  requester index
- rsp_num, rsp_den  out  WIDTH each  result
- rsp_dz  out  1  result denominator is zero
- rsp_err  out  1  watchdog abort (tied 0 without the macro)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbiter picks the first asserted req_valid at or after rr_ptr, wrapping. req_ready is driven combinationally and is one-hot for that winner, only in IDLE. It is all-zero in other states or when no request is pending.
- Accept = req_valid[i] & req_ready[i]. On accept: latch op/operands/id, rr_ptr <= i+1 mod NREQ, go to ISSUE.
- ISSUE: u_start=1 for exactly one cycle, go to WAIT. u_rdy is ignored in ISSUE.
- WAIT: on u_rdy, latch u_s_num/u_s_den into rsp_num/rsp_den, set rsp_dz = (u_s_den==0), go to RESP.
- RESP: rsp_valid=1. Outputs are held stable until rsp_valid & rsp_ready, then go to IDLE.
- Requesters hold req_valid and operands until accepted. Deasserting before accept is legal; the grant moves on.
- No arithmetic is performed here. Results pass through unmodified, with no normalisation. DIV with r_num==0 is forwarded to the unit; rsp_dz flags the result.
- u_op/u_* operands hold their latched values from accept until the next accept.

## Timing
- Reset (async assert, sync release): state IDLE, rr_ptr 0, req_ready 0, u_start 0, u_op 0, u_* 0, rsp_valid 0, rsp_id 0, rsp_num 0, rsp_den 0, rsp_dz 0, rsp_err 0.
- Accept in cycle T -> u_start in T+1. u_rdy first sampled in T+2.
- u_rdy in cycle W -> rsp_valid from W+1.
- Response accepted in cycle R -> next accept possible in R+1 (IDLE), with u_start in R+2.
- Minimum overhead is 3 cycles plus unit latency plus response wait. Throughput is one op in flight.
- rst mid-operation aborts the op with no response. The unit shares rst.
- Simultaneous requests: granted in strict rotation from rr_ptr. No requester waits more than NREQ-1 ops.

## Configuration
- RAT_SCHED_TIMEOUT_EN defined: a cycle counter clears on entering WAIT. If it reaches TIMEOUT without u_rdy, go to RESP with rsp_err=1, rsp_num=0, rsp_den=0, rsp_dz=1.
- Not defined: no counter. WAIT is unbounded and rsp_err is constant 0.

## Structure
- Shared package rat_pkg: op encoding (ADD/SUB/MUL/DIV as 2-bit enum), FSM state enum, default WIDTH constant.
- One sub-module: rat_rr_arb (NREQ request vector, rr_ptr in, one-hot grant out, combinational).

## Test plan
- Single request on 0, ADD 1/2 + 1/3, unit model with 4-cycle latency -> u_start one cycle after accept; rsp_id=0, rsp 5/6, rsp_dz=0.
- All four requesters valid at once, SUB 3/4 - 1/2 each -> grants 0,1,2,3 in order, each rsp 2/8, exactly one u_start per op.
- rr_ptr=2 after one op; requesters 0 and 3 valid -> 3 granted before 0.
- rsp_ready held low 10 cycles -> rsp_* stable, req_ready all-zero, no u_start.
- rst asserted in WAIT -> all outputs zero immediately; next request is serviced normally from IDLE.
- With RAT_SCHED_TIMEOUT_EN, TIMEOUT=8, unit never asserts u_rdy -> rsp_err=1, rsp_dz=1, 0/0 after 8 WAIT cycles.
